mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mycpu_pkg.sv | 16 +
 rtl/mem_port_arbiter_if.sv | 26 ++
 rtl/arb_owner_fifo.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared types for the memory port arbiter: owner encoding and FSM states.
// Imported by the arbiter top and its owner-tracking FIFO.
package mycpu_pkg;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory port bundle: request side (mem_req..mem_wdata) and
// response side (mem_addr_ok, mem_data_ok, mem_rdata).
interface mem_port_arbiter_if;

  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb,
    output mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb,
    input  mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );

endinterface

// File: rtl/arb_owner_fifo.sv
// In-order tracker of which requester owns each outstanding transaction.
// Ports: clk, reset, push/din, pop, dout (head), full, empty.
module arb_owner_fifo
  import mycpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t din,
  input  logic   pop,
  output owner_t dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  owner_t        q [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = q[rp];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        q[wp] <= din;
        wp    <= wp + 1'b1;
      end
      if (do_pop)
        rp <= rp + 1'b1;
      // push and pop together leave the count unchanged
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one shared memory port.
// Ports: clk, reset, inst_*/data_* CPU sides, rdata, mem (master bundle).
// Optional starvation guard for fetch: MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import mycpu_pkg::*;
#(
  parameter int OUTSTANDING_DEPTH = 2,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] rdata,
  mem_port_arbiter_if.master mem
);

  arb_state_t state;
  arb_state_t state_nxt;
  owner_t     owner;
  owner_t     head;
  logic       sel_req;
  logic       accept;
  logic       pop;
  logic       full;
  logic       empty;
  logic       starve;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  // counts fetch wait cycles; saturates so fetch keeps priority
  always_ff @(posedge clk) begin
    if (reset || !inst_req || inst_addr_ok)
      starve_cnt <= '0;
    else if (starve_cnt != SW'(STARVE_LIMIT))
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign starve = (starve_cnt == SW'(STARVE_LIMIT));
`else
  assign starve = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (mem.mem_req && !mem.mem_addr_ok)
          state_nxt = (owner == OWN_DATA) ? ST_HOLD_D : ST_HOLD_I;
      ST_HOLD_I, ST_HOLD_D:
        if (accept)
          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    owner = OWN_INST;
    unique case (state)
      ST_HOLD_I: owner = OWN_INST;
      ST_HOLD_D: owner = OWN_DATA;
      default:
        if (data_req && !(starve && inst_req))
          owner = OWN_DATA;
    endcase

    sel_req = (owner == OWN_DATA) ? data_req : inst_req;

    mem.mem_req   = sel_req & ~full & ~reset;
    mem.mem_addr  = inst_addr;
    mem.mem_wdata = data_wdata;
    mem.mem_wr    = 1'b0;
    mem.mem_wstrb = 4'h0;
    if (owner == OWN_DATA) begin
      mem.mem_addr  = data_addr;
      mem.mem_wr    = data_wr;
      mem.mem_wstrb = data_wstrb;
    end

    accept       = mem.mem_req & mem.mem_addr_ok;
    inst_addr_ok = accept & (owner == OWN_INST);
    data_addr_ok = accept & (owner == OWN_DATA);

    // a response with nothing outstanding is dropped
    pop          = mem.mem_data_ok & ~empty & ~reset;
    inst_data_ok = pop & (head == OWN_INST);
    data_data_ok = pop & (head == OWN_DATA);
  end

  assign rdata = mem.mem_rdata;

  arb_owner_fifo #(
    .DEPTH (OUTSTANDING_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .din   (owner),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

endmodule
